// File: rtl/fifo_pkg.sv
// Pointer arithmetic shared by the single-clock and gray-coded async FIFOs.
// Callers pass pointers zero-extended to 32 bits together with the address width.
package fifo_pkg;

    function automatic int DEPTH(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    function automatic logic ptr_empty(input logic [31:0] wr, input logic [31:0] rd);
        return wr == rd;
    endfunction

    // Full when the address bits match but the wrap bits differ.
    function automatic logic ptr_full(input logic [31:0] wr, input logic [31:0] rd,
                                      input int addr_bits);
        logic [31:0] lo_mask;
        lo_mask = (32'd1 << addr_bits) - 32'd1;
        return ((wr & lo_mask) == (rd & lo_mask)) && (wr[addr_bits] != rd[addr_bits]);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
// No reset; contents and read register power up undefined.
module sync_fifo_mem #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);
    import fifo_pkg::*;

    logic [DATA_BITS-1:0] mem [DEPTH(ADDR_BITS)];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a one-cycle registered read port.
module sync_fifo #(
    parameter int P_DATA_BITS = 8,
    parameter int P_ADDR_BITS = 4,
    parameter int P_AFULL     = 14,
    parameter int P_AEMPTY    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [P_DATA_BITS-1:0] wr_data,
    input  logic                   rd_en,
    output logic [P_DATA_BITS-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [P_ADDR_BITS:0]   count,
    output logic                   wr_err,
    output logic                   rd_err
);
    import fifo_pkg::*;

    localparam int PW = P_ADDR_BITS + 1;
    localparam logic [PW-1:0] AFULL_LVL  = PW'(P_AFULL);
    localparam logic [PW-1:0] AEMPTY_LVL = PW'(P_AEMPTY);

    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   rd_seen;
    logic [P_DATA_BITS-1:0] mem_q;

    assign empty        = ptr_empty(32'(wr_ptr), 32'(rd_ptr));
    assign full         = ptr_full(32'(wr_ptr), 32'(rd_ptr), P_ADDR_BITS);
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AFULL_LVL);
    assign almost_empty = (count <= AEMPTY_LVL);
    assign wr_acc       = wr_en & ~full;
    assign rd_acc       = rd_en & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            wr_err   <= 1'b0;
            rd_err   <= 1'b0;
            rd_seen  <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            if (rd_acc)
                rd_seen <= 1'b1;
            rd_valid <= rd_acc;
            wr_err   <= wr_en & full;
            rd_err   <= rd_en & empty;
        end
    end

    sync_fifo_mem #(
        .DATA_BITS (P_DATA_BITS),
        .ADDR_BITS (P_ADDR_BITS)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[P_ADDR_BITS-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[P_ADDR_BITS-1:0]),
        .rd_data (mem_q)
    );

    // The RAM read register has no reset, so rd_data reads as zero until the
    // first pop after reset; afterwards it holds the last popped word.
    assign rd_data = rd_seen ? mem_q : '0;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized scoreboard bench for sync_fifo against a queue-based FIFO model.
module tb_sync_fifo;

    localparam int DEPTH_W = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       wr_err;
    logic       rd_err;

    int         checks = 0;
    int         errors = 0;

    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic       e_valid;
    logic       e_wr_err;
    logic       e_rd_err;
    logic [7:0] last_rd;
    bit         mon_on;

    sync_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .wr_err       (wr_err),
        .rd_err       (rd_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one request cycle and advance the model to the state after the next edge.
    task automatic step(input bit we, input logic [7:0] wd, input bit re);
        int  n;
        bit  wacc;
        bit  racc;
        @(negedge clk);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        n        = m_q.size();
        wacc     = we && (n < DEPTH_W);
        racc     = re && (n > 0);
        e_wr_err = we && (n == DEPTH_W);
        e_rd_err = re && (n == 0);
        e_valid  = racc;
        if (racc)
            exp_q.push_back(m_q.pop_front());
        if (wacc)
            m_q.push_back(wd);
    endtask

    task automatic reset_model();
        m_q.delete();
        exp_q.delete();
        e_valid  = 1'b0;
        e_wr_err = 1'b0;
        e_rd_err = 1'b0;
        last_rd  = 8'h00;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_aempty", 32'(almost_empty), 32'd1);
        check_eq("rst_afull", 32'(almost_full), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_wr_err", 32'(wr_err), 32'd0);
        check_eq("rst_rd_err", 32'(rd_err), 32'd0);
    endtask

    // Monitor: compares flags against the model and pops the scoreboard on rd_valid.
    initial begin
        logic [7:0] want;
        int         n;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on && rst_n) begin
                n = m_q.size();
                check_eq("count", 32'(count), 32'(n));
                check_eq("full", 32'(full), 32'(n == DEPTH_W));
                check_eq("empty", 32'(empty), 32'(n == 0));
                check_eq("almost_full", 32'(almost_full), 32'(n >= 14));
                check_eq("almost_empty", 32'(almost_empty), 32'(n <= 2));
                check_eq("wr_err", 32'(wr_err), 32'(e_wr_err));
                check_eq("rd_err", 32'(rd_err), 32'(e_rd_err));
                check_eq("rd_valid", 32'(rd_valid), 32'(e_valid));
                if (rd_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rd_unexpected actual=%0h required=none", rd_data);
                    end else begin
                        want = exp_q.pop_front();
                        check_eq("rd_data", 32'(rd_data), 32'(want));
                        last_rd = want;
                    end
                end else begin
                    check_eq("rd_hold", 32'(rd_data), 32'(last_rd));
                end
            end
        end
    end

    initial begin
        mon_on  = 1'b0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;
        reset_model();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // Fill to full, then attempt one overflow write.
        for (int i = 0; i < 16; i++)
            step(1'b1, 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check_eq("t1_full", 32'(full), 32'd1);
        check_eq("t1_count", 32'(count), 32'd16);
        step(1'b1, 8'hAA, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check_eq("t2_count", 32'(count), 32'd16);

        // Drain completely, then one underflow read.
        for (int i = 0; i < 16; i++)
            step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check_eq("t3_empty", 32'(empty), 32'd1);

        // Half-full streaming long enough to wrap the pointers.
        for (int i = 0; i < 8; i++)
            step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++)
            step(1'b1, 8'($urandom), 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check_eq("t4_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++)
            step(1'b0, 8'h00, 1'b1);

        // Simultaneous request on an empty FIFO.
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h5C, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check_eq("t5_last", 32'(rd_data), 32'h5C);

        // Asynchronous reset in the middle of a burst at count 9.
        for (int i = 0; i < 9; i++)
            step(1'b1, 8'($urandom), 1'b0);
        @(posedge clk);
        #2;
        check_eq("t6_pre_count", 32'(count), 32'd9);
        mon_on = 1'b0;
        rst_n  = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        #1;
        check_reset_outputs();
        reset_model();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // Randomized traffic with varying write/read bias.
        for (int phase = 0; phase < 4; phase++) begin
            int wp;
            int rp;
            wp = (phase == 0) ? 80 : (phase == 1) ? 20 : (phase == 2) ? 50 : 65;
            rp = 100 - wp;
            if (phase == 2)
                rp = 50;
            for (int i = 0; i < 150; i++)
                step(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < rp));
        end
        for (int i = 0; i < 20; i++)
            step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #2;
        check_eq("drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
